// File: rtl/ne16_streamout_scheduler.sv
// NE16 streamout scheduler: walks accumulator columns in order, one-hot enabling each
// column and steering the store_out serializer until every column has delivered its beats.
module ne16_streamout_scheduler #(
  parameter int unsigned NR_COLUMN = 9,
  parameter int unsigned BEAT_W    = 8,
  localparam int unsigned COL_W    = $clog2(NR_COLUMN + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [COL_W-1:0]     nr_cols_i,
  input  logic [BEAT_W-1:0]    nr_beats_i,
  input  logic                 out_valid_i,
  input  logic                 out_ready_i,
  output logic [NR_COLUMN-1:0] enable_acc_o,
  output logic [COL_W-1:0]     ser_sel_o,
  output logic                 ser_first_o,
  output logic                 ser_last_o,
  output logic                 clear_des_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {StIdle, StArm, StStream, StDone} state_e;

  state_e              state_q, state_d;
  logic [COL_W-1:0]    cols_q, cols_d;
  logic [BEAT_W-1:0]   beats_q, beats_d;
  logic [COL_W-1:0]    col_cnt_q, col_cnt_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                handshake, last_col, last_beat, stream;

  assign handshake = out_valid_i & out_ready_i;
  assign last_col  = (col_cnt_q == cols_q - COL_W'(1));
  assign last_beat = (beat_cnt_q == beats_q - BEAT_W'(1));
  assign stream    = (state_q == StStream);

  always_comb begin
    state_d    = state_q;
    cols_d     = cols_q;
    beats_d    = beats_q;
    col_cnt_d  = col_cnt_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cols_d  = (nr_cols_i > COL_W'(NR_COLUMN)) ? COL_W'(NR_COLUMN) : nr_cols_i;
          beats_d = nr_beats_i;
          state_d = StArm;
        end
      end
      StArm: begin
        col_cnt_d  = '0;
        beat_cnt_d = '0;
        // An empty pass still pulses clear_des and done, but never enables a column.
        state_d    = (cols_q == '0 || beats_q == '0) ? StDone : StStream;
      end
      StStream: begin
        if (handshake) begin
          if (last_beat) begin
            beat_cnt_d = '0;
            if (last_col) begin
              col_cnt_d = '0;
              state_d   = StDone;
            end else begin
              col_cnt_d = col_cnt_q + COL_W'(1);
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clear_i) begin
      state_d    = StIdle;
      cols_d     = '0;
      beats_d    = '0;
      col_cnt_d  = '0;
      beat_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cols_q     <= '0;
      beats_q    <= '0;
      col_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cols_q     <= cols_d;
      beats_q    <= beats_d;
      col_cnt_q  <= col_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Outputs decode only registered state, so they move solely on clock edges with a handshake.
  always_comb begin
    enable_acc_o = '0;
    for (int i = 0; i < NR_COLUMN; i++) begin
      enable_acc_o[i] = stream && (col_cnt_q == COL_W'(i));
    end
    ser_sel_o   = stream ? col_cnt_q : '0;
    ser_first_o = stream && (col_cnt_q == '0) && (beat_cnt_q == '0);
    ser_last_o  = stream && last_col && last_beat;
    clear_des_o = (state_q == StArm);
    busy_o      = (state_q == StArm) || stream;
    done_o      = (state_q == StDone);
  end

endmodule

// File: tb/tb_ne16_streamout_scheduler.sv
// Self-checking bench for ne16_streamout_scheduler: table-driven and random passes
// against a per-pass queue of expected beat columns.
module tb_ne16_streamout_scheduler;

  localparam int NR_COLUMN = 9;
  localparam int BEAT_W    = 8;
  localparam int COL_W     = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clear = 1'b0;
  logic                 start = 1'b0;
  logic [COL_W-1:0]     nr_cols = '0;
  logic [BEAT_W-1:0]    nr_beats = '0;
  logic                 out_valid = 1'b0;
  logic                 out_ready = 1'b0;
  logic [NR_COLUMN-1:0] enable_acc;
  logic [COL_W-1:0]     ser_sel;
  logic                 ser_first, ser_last, clear_des, busy, done;

  int n_vec = 0;
  int n_err = 0;

  ne16_streamout_scheduler #(
    .NR_COLUMN(NR_COLUMN),
    .BEAT_W   (BEAT_W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .start_i     (start),
    .nr_cols_i   (nr_cols),
    .nr_beats_i  (nr_beats),
    .out_valid_i (out_valid),
    .out_ready_i (out_ready),
    .enable_acc_o(enable_acc),
    .ser_sel_o   (ser_sel),
    .ser_first_o (ser_first),
    .ser_last_o  (ser_last),
    .clear_des_o (clear_des),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " enable"}, 32'(enable_acc), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " clear_des"}, 32'(clear_des), 0);
    chk({tag, " ser_sel"}, 32'(ser_sel), 0);
  endtask

  // Starts a pass at the current negedge and follows it to the done_o cycle.
  // mode: 0 valid/ready always, 1 ready toggling, 2 random. wiggle: random start/config mid-pass.
  task automatic run_pass(input int cols, input int beats, input int mode, input bit wiggle);
    int q[$];
    int eff_cols, n_done, budget;
    bit tog, v, r;
    eff_cols = (cols > NR_COLUMN) ? NR_COLUMN : cols;
    for (int c = 0; c < eff_cols; c++)
      for (int b = 0; b < beats; b++) q.push_back(c);
    nr_cols  = COL_W'(cols);
    nr_beats = BEAT_W'(beats);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    nr_cols  = COL_W'($urandom);
    nr_beats = BEAT_W'($urandom);
    chk("arm clear_des", 32'(clear_des), 1);
    chk("arm busy", 32'(busy), 1);
    chk("arm enable", 32'(enable_acc), 0);
    chk("arm done", 32'(done), 0);
    @(negedge clk);
    n_done = 0;
    budget = 0;
    tog    = 1'b1;
    while (q.size() > 0 && budget < 5000) begin
      chk("enable", 32'(enable_acc), 32'(1) << q[0]);
      chk("ser_sel", 32'(ser_sel), 32'(q[0]));
      chk("ser_first", 32'(ser_first), 32'(n_done == 0));
      chk("ser_last", 32'(ser_last), 32'(q.size() == 1));
      chk("stream busy", 32'(busy), 1);
      chk("stream done", 32'(done), 0);
      case (mode)
        0: begin v = 1'b1; r = 1'b1; end
        1: begin v = 1'b1; r = tog; tog = ~tog; end
        default: begin v = ($urandom_range(0, 3) != 0); r = $urandom_range(0, 1) != 0; end
      endcase
      out_valid = v;
      out_ready = r;
      if (wiggle) begin
        start    = ($urandom_range(0, 3) == 0);
        nr_cols  = COL_W'($urandom);
        nr_beats = BEAT_W'($urandom);
      end
      @(negedge clk);
      if (v && r) begin
        void'(q.pop_front());
        n_done++;
      end
      budget++;
    end
    out_valid = 1'b0;
    out_ready = 1'b0;
    start     = 1'b0;
    if (q.size() > 0) chk("stream budget expired", 32'(q.size()), 0);
    chk("done pulse", 32'(done), 1);
    chk("done enable", 32'(enable_acc), 0);
    chk("done busy", 32'(busy), 0);
  endtask

  typedef struct {
    int cols;
    int beats;
    int mode;
    bit wiggle;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{cols: 3,  beats: 2,   mode: 0, wiggle: 1'b0};
    tbl[1] = '{cols: 9,  beats: 1,   mode: 1, wiggle: 1'b0};
    tbl[2] = '{cols: 0,  beats: 5,   mode: 0, wiggle: 1'b0};
    tbl[3] = '{cols: 4,  beats: 0,   mode: 0, wiggle: 1'b0};
    tbl[4] = '{cols: 15, beats: 2,   mode: 2, wiggle: 1'b1};
    tbl[5] = '{cols: 1,  beats: 1,   mode: 0, wiggle: 1'b0};
    tbl[6] = '{cols: 10, beats: 3,   mode: 2, wiggle: 1'b1};
    tbl[7] = '{cols: 1,  beats: 255, mode: 0, wiggle: 1'b0};
    tbl[8] = '{cols: 9,  beats: 3,   mode: 1, wiggle: 1'b1};

    // Reset state, checked before the first clock edge takes effect.
    #1;
    chk_idle("reset");
    chk("reset first", 32'(ser_first), 0);
    chk("reset last", 32'(ser_last), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post reset");

    foreach (tbl[i]) begin
      run_pass(tbl[i].cols, tbl[i].beats, tbl[i].mode, tbl[i].wiggle);
      @(negedge clk);
      chk_idle("after table pass");
    end

    // Start asserted in the DONE cycle must be dropped.
    run_pass(2, 1, 0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start in done busy", 32'(busy), 0);
    chk("start in done clear_des", 32'(clear_des), 0);

    // Async reset at column 4, beat 1.
    nr_cols  = 4'd9;
    nr_beats = 8'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    out_valid = 1'b1;
    out_ready = 1'b1;
    repeat (9) @(negedge clk);
    out_valid = 1'b0;
    out_ready = 1'b0;
    chk("pre-reset ser_sel", 32'(ser_sel), 4);
    chk("pre-reset enable", 32'(enable_acc), 32'h10);
    rst_n = 1'b0;
    #1;
    chk_idle("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("no done after reset", 32'(done), 0);
    run_pass(2, 2, 0, 1'b0);
    @(negedge clk);

    // Soft clear coinciding with a handshake.
    nr_cols  = 4'd2;
    nr_beats = 8'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre-clear enable", 32'(enable_acc), 1);
    out_valid = 1'b1;
    out_ready = 1'b1;
    clear     = 1'b1;
    @(negedge clk);
    out_valid = 1'b0;
    out_ready = 1'b0;
    clear     = 1'b0;
    chk_idle("after clear");
    @(negedge clk);
    chk_idle("after clear+1");
    run_pass(3, 1, 0, 1'b0);
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      run_pass($urandom_range(0, 15), $urandom_range(0, 6), 2, 1'b1);
      @(negedge clk);
      chk("random idle busy", 32'(busy), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
